// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants used by the port arbiter and the
// VGA pixel-alignment logic.
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_RD_LAT = 2;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } fb_grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding queued {addr,data} camera writes.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter  int WIDTH = FB_ADDR_W + FB_DATA_W,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the level counter alone decides validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle they ask,
// queued camera writes drain into the BRAM on the remaining cycles.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter  int ADDR_W   = FB_ADDR_W,
    parameter  int DATA_W   = FB_DATA_W,
    parameter  int WQ_DEPTH = 4,
    localparam int LVL_W    = $clog2(WQ_DEPTH) + 1
) (
    input  logic              CLK25,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              ovf_clr,
    output logic              ovf,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W+DATA_W-1:0] w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_wr_ready;
    fb_grant_e                w_grant;

    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [FB_RD_LAT-1:0] r_rd_pipe;
    logic                 r_rd_valid;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_ovf;

    // A pop in the same cycle never frees a slot for this cycle's offer.
    assign w_wr_ready = ~w_full & ~rst;
    assign w_push     = wr_valid & w_wr_ready;
    assign w_pop      = (w_grant == GNT_WRITE);

    always_comb begin
        w_grant = GNT_IDLE;
        if (rd_req)        w_grant = GNT_READ;
        else if (!w_empty) w_grant = GNT_WRITE;
    end

    fb_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .i_clk   (CLK25),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_din   ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK25) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_pipe   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            // Address stage, then BRAM output stage, then capture into rd_data.
            r_rd_pipe  <= {r_rd_pipe[FB_RD_LAT-2:0], rd_req};
            r_rd_valid <= r_rd_pipe[FB_RD_LAT-1];
            if (r_rd_pipe[FB_RD_LAT-1]) r_rd_data <= mem_rdata;

            case (w_grant)
                GNT_READ: begin
                    r_mem_addr <= rd_addr;
                    r_mem_we   <= 1'b0;
                end
                GNT_WRITE: begin
                    r_mem_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
                    r_mem_wdata <= w_head[DATA_W-1:0];
                    r_mem_we    <= 1'b1;
                end
                default: r_mem_we <= 1'b0;
            endcase

            if (wr_valid && !w_wr_ready) r_ovf <= 1'b1;
            else if (ovf_clr)            r_ovf <= 1'b0;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign ovf       = r_ovf;
    assign wr_ready  = w_wr_ready;

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares one single-port frame-buffer BRAM between the OV7670 capture side (writes) and the VGA display side (reads).
- Display reads have strict priority. Each read is a single cycle with fixed latency, so pixels arrive in lockstep with the active area.
- Camera writes are buffered in a small write FIFO. The FIFO drains into the BRAM on every cycle with no read request, mostly during blanking.
- Sits between the capture/address logic, the VGA timing generator and the frame-buffer RAM. Runs entirely in the 25 MHz pixel domain.

Parameters:
ADDR_W, 17, frame-buffer address width (320x240 = 76800 words).
DATA_W, 12, pixel width (RGB444).
WQ_DEPTH, 4, write FIFO depth; power of two, minimum 2.

Ports:
CLK25  in  1  pixel clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
rd_req  in  1  display read request for this cycle (driven from activeArea)
rd_addr  in  ADDR_W  read address, sampled with rd_req
rd_data  out  DATA_W  read pixel
rd_valid  out  1  rd_data valid
wr_valid  in  1  camera pixel offered
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_ready  out  1  FIFO can accept; transfer happens when wr_valid & wr_ready
ovf_clr  in  1  clears ovf
ovf  out  1  sticky: wr_valid was seen while wr_ready=0
fifo_level  out  clog2(WQ_DEPTH)+1  current FIFO occupancy
mem_addr  out  ADDR_W  BRAM address (registered)
mem_we  out  1  BRAM write enable (registered)
mem_wdata  out  DATA_W  BRAM write data (registered)
mem_rdata  in  DATA_W  BRAM read data; valid one cycle after the address is presented

Behaviour:
- Reset values (rst high at an edge):
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - rd_valid=0, rd_data=0, ovf=0.
  - FIFO emptied; fifo_level=0.
  - wr_ready=0 while rst is high.
  - Any in-flight read is discarded: the rd_valid pipeline is cleared.
- Grant decision at each edge, per cycle:
  - rd_req=1: mem_addr<=rd_addr, mem_we<=0. Read granted.
  - Else if FIFO non-empty: mem_addr/mem_wdata <= FIFO head, mem_we<=1. Pop head.
  - Else: mem_we<=0, mem_addr holds its value.
- Read latency:
  - rd_req sampled at edge t gives rd_valid=1 in the cycle after edge t+2, with rd_data = mem_rdata captured at edge t+2.
  - rd_valid is a two-stage delayed copy of granted reads.
  - Back-to-back reads are supported at one per cycle.
- Write FIFO:
  - Push when wr_valid & wr_ready. wr_ready = (fifo_level < WQ_DEPTH) & ~rst. It is combinational from registered state.
  - When full, a pop in the same cycle does not raise wr_ready in that cycle.
  - Push and pop in the same cycle: level unchanged, ordering preserved (FIFO order).
  - Pointers wrap modulo WQ_DEPTH.
  - Pop only when non-empty and rd_req=0.
- Overflow:
  - ovf <= 1 at any edge with wr_valid=1 & wr_ready=0. The pixel is dropped, not retried.
  - ovf_clr=1 clears ovf. If a new overflow event occurs in the same cycle, set wins.
- Write-read hazard: a read of an address still queued in the FIFO returns the old BRAM contents. No forwarding.
- No write is ever issued in a cycle with rd_req=1. Writes can starve indefinitely under continuous rd_req; ovf reports the resulting loss.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W and FB_DATA_W constants.
  - pixel_t (DATA_W) and fb_addr_t (ADDR_W) typedefs.
  - FB_RD_LAT=2, also used by the VGA pixel-alignment logic.
- One sub-module fb_wr_fifo: synchronous FIFO of {addr,data} with push/pop/level/full/empty. The arbiter holds only the grant logic and the read-valid pipeline.

Test Plan:
- Reset: assert rst for 3 cycles while wr_valid=1 and rd_req=1 -> wr_ready=0, mem_we=0, rd_valid=0, fifo_level=0; one cycle after release wr_ready=1.
- Read latency: rd_req=1 with rd_addr=0x00010, then 0x00011, with the BRAM model preloaded with 0xABC and 0x123 -> rd_valid rises exactly 2 cycles after the first request; rd_data=0xABC then 0x123 on consecutive cycles; mem_we stays 0 throughout.
- Write drain: with rd_req=0, push 3 pixels (addr 5,6,7; data 0x111,0x222,0x333) -> mem_we=1 on 3 consecutive cycles with matching addr/data in order; fifo_level ends at 0.
- Priority/full: hold rd_req=1 for 10 cycles while offering 6 writes -> first 4 accepted (fifo_level=4); wr_ready=0 afterwards and ovf=1 on the 5th offer; after rd_req drops, 4 writes drain in order with no read interleaved.
- Simultaneous push/pop: FIFO at level 2, rd_req=0, wr_valid=1 -> level stays 2 and write order is preserved.
- ovf_clr: ovf=1; pulse ovf_clr with no overflow -> ovf=0; pulse ovf_clr together with an overflow event -> ovf remains 1.
